// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response handshake and data-memory bus bundle for the load/store unit
// slave: the load/store unit itself; master: the datapath plus data memory facing it.
interface load_store_unit_if #(
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store initiator for a word-wide data memory
// Sub-word stores do read-modify-write; loads return the sign/zero-extended lane.
module load_store_unit #(
  parameter int ADDR_W          = 5,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              we_q;
  logic              uns_q;
  logic              err_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       mem_wdata_q;
  logic              accept;
  logic              req_bad;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       load_ext;
  logic [31:0]       store_merge;

  assign accept = (state == IDLE) && bus.req_valid;

  always_comb begin
    req_bad = (bus.req_size == 2'b11);
    if (ERR_ON_MISALIGN) begin
      if (bus.req_size == 2'b01 && bus.req_addr[0])
        req_bad = 1'b1;
      if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
        req_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad)
            state_nxt = RESP;
          else if (bus.req_we && bus.req_size == 2'b10)
            state_nxt = WR;
          else
            state_nxt = RD;
        end
      end
      RD:      state_nxt = we_q ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.mem_read   = (state == RD);
    bus.mem_write  = (state == WR);
    bus.resp_valid = (state == RESP);
    bus.resp_err   = (state == RESP) && err_q;
    bus.resp_rdata = rdata_q;
    bus.mem_wdata  = mem_wdata_q;
    bus.mem_addr   = addr_q[ADDR_W+1:2];
  end

  // Lane extraction for loads and lane insertion for read-modify-write stores.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = bus.mem_rdata[7:0];
      2'd1:    lane_b = bus.mem_rdata[15:8];
      2'd2:    lane_b = bus.mem_rdata[23:16];
      default: lane_b = bus.mem_rdata[31:24];
    endcase
    lane_h = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    case (size_q)
      2'b00:   load_ext = {{24{lane_b[7] & ~uns_q}}, lane_b};
      2'b01:   load_ext = {{16{lane_h[15] & ~uns_q}}, lane_h};
      default: load_ext = bus.mem_rdata;
    endcase

    store_merge = bus.mem_rdata;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    store_merge[7:0]   = wdata_q[7:0];
        2'd1:    store_merge[15:8]  = wdata_q[7:0];
        2'd2:    store_merge[23:16] = wdata_q[7:0];
        default: store_merge[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      store_merge[31:16] = wdata_q;
    end else begin
      store_merge[15:0] = wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      uns_q   <= bus.req_unsigned;
      err_q   <= req_bad;
      size_q  <= bus.req_size;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata[15:0];
      rdata_q <= '0;
      if (bus.req_we && bus.req_size == 2'b10 && !req_bad)
        mem_wdata_q <= bus.req_wdata;
    end else if (state == RD) begin
      // The read word is sampled at the end of RD, so memory must hold mem_addr stable.
      if (we_q)
        mem_wdata_q <= store_merge;
      else
        rdata_q <= load_ext;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();
  load_store_unit #(.ADDR_W(ADDR_W), .ERR_ON_MISALIGN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] mem [0:31];
  logic        pl_we = 1'b0;
  logic [4:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_we)
      mem[pl_addr] <= pl_data;
    else if (bus.mem_write)
      mem[bus.mem_addr] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  int tests = 0;
  int fails = 0;
  int orphan_err = 0;

  logic [7:0] refm [0:127];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Byte-addressed reference: a request touches 2**size consecutive bytes.
  task automatic ref_access(input logic we, input logic [1:0] sz, input logic uns, input logic [6:0] addr,
                            input logic [31:0] wd, output logic err, output logic [31:0] rd, output int lat);
    int n;
    int a;
    int base;
    longint v;
    n = 1 << sz;
    a = int'(addr);
    rd = '0;
    err = (sz == 2'b11) || (a % n != 0);
    if (err) begin
      lat = 1;
      return;
    end
    base = a - (a % n);
    if (we) begin
      for (int i = 0; i < n; i++)
        refm[base + i] = 8'(wd >> (8 * i));
      lat = (n == 4) ? 2 : 3;
    end else begin
      v = 0;
      for (int i = 0; i < n; i++)
        v += longint'(refm[base + i]) << (8 * i);
      if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1)))
        v -= longint'(1) << (8 * n);
      rd = v[31:0];
      lat = 2;
    end
  endtask

  task automatic preload(input int w, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1;
    pl_addr = 5'(w);
    pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
    for (int i = 0; i < 4; i++)
      refm[4 * w + i] = 8'(d >> (8 * i));
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns, input logic [6:0] addr,
                        input logic [31:0] wd, output logic err, output logic [31:0] rd, output int lat,
                        output int nrd, output int nwr, output logic [4:0] maddr, output logic [31:0] hold);
    int w;
    @(negedge clk);
    w = 0;
    while (!bus.req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_size = sz;
    bus.req_unsigned = uns;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; maddr = '0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.mem_read) begin nrd++; maddr = bus.mem_addr; end
      if (bus.mem_write) begin nwr++; maddr = bus.mem_addr; end
      if (bus.resp_err && !bus.resp_valid) orphan_err++;
    end while (!bus.resp_valid && lat < 8);
    if (!bus.resp_valid) lat = 99;
    err = bus.resp_err;
    rd = bus.resp_rdata;
    @(negedge clk);
    hold = bus.resp_rdata;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [6:0]  addr;
    logic [31:0] wd;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_nrd;
    int          exp_nwr;
    logic [31:0] exp_w3;
  } vec_t;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [6:0]  addr;
    logic [31:0] wd;
  } req_t;

  vec_t        vt [9];
  req_t        bq [4];
  logic        e, re;
  logic [31:0] r, h, rr;
  int          l, nr, nw, rl;
  logic [4:0]  ma;
  logic [31:0] exp_rd_q [$];
  logic        exp_err_q [$];
  logic [31:0] got_rd_q [$];
  logic        got_err_q [$];
  int          idx, cyc, resp_seen;
  logic        accepted;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 2'b00, 1'b0, 7'd13, 32'h0,      1'b0, 32'hFFFF_FFF0, 2, 1, 0, 32'h8081_F0F1};
    vt[1] = '{1'b0, 2'b00, 1'b1, 7'd13, 32'h0,      1'b0, 32'h0000_00F0, 2, 1, 0, 32'h8081_F0F1};
    vt[2] = '{1'b0, 2'b01, 1'b0, 7'd14, 32'h0,      1'b0, 32'hFFFF_8081, 2, 1, 0, 32'h8081_F0F1};
    vt[3] = '{1'b0, 2'b01, 1'b1, 7'd14, 32'h0,      1'b0, 32'h0000_8081, 2, 1, 0, 32'h8081_F0F1};
    vt[4] = '{1'b0, 2'b10, 1'b1, 7'd12, 32'h0,      1'b0, 32'h8081_F0F1, 2, 1, 0, 32'h8081_F0F1};
    vt[5] = '{1'b1, 2'b00, 1'b0, 7'd12, 32'h55,     1'b0, 32'h0,         3, 1, 1, 32'h8081_F055};
    vt[6] = '{1'b1, 2'b01, 1'b0, 7'd14, 32'h1234,   1'b0, 32'h0,         3, 1, 1, 32'h1234_F055};
    vt[7] = '{1'b0, 2'b10, 1'b0, 7'd13, 32'h0,      1'b1, 32'h0,         1, 0, 0, 32'h1234_F055};
    vt[8] = '{1'b1, 2'b11, 1'b0, 7'd12, 32'hFFFF_FFFF, 1'b1, 32'h0,      1, 0, 0, 32'h1234_F055};

    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    rst_n = 1'b1;

    for (int w = 0; w < 32; w++)
      preload(w, $urandom);
    preload(3, 32'h8081_F0F1);

    for (int i = 0; i < 9; i++) begin
      do_req(vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd, e, r, l, nr, nw, ma, h);
      ref_access(vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd, re, rr, rl);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vt[i].exp_err));
      chk($sformatf("vec%0d_rdata", i), r, vt[i].exp_rd);
      chk($sformatf("vec%0d_latency", i), 32'(l), 32'(vt[i].exp_lat));
      chk($sformatf("vec%0d_mem_reads", i), 32'(nr), 32'(vt[i].exp_nrd));
      chk($sformatf("vec%0d_mem_writes", i), 32'(nw), 32'(vt[i].exp_nwr));
      chk($sformatf("vec%0d_rdata_hold", i), h, vt[i].exp_rd);
      chk($sformatf("vec%0d_word3", i), mem[3], vt[i].exp_w3);
      if (vt[i].exp_nrd + vt[i].exp_nwr > 0)
        chk($sformatf("vec%0d_mem_addr", i), 32'(ma), 32'(vt[i].addr >> 2));
    end

    // Reset while a word store sits in WR: the write must never land.
    preload(2, 32'h1111_2222);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 7'd8;
    bus.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    chk("midwr_write_active", 32'(bus.mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midwr_write_dropped", 32'(bus.mem_write), 32'd0);
    chk("midwr_ready", 32'(bus.req_ready), 32'd1);
    resp_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.resp_valid) resp_seen++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.resp_valid) resp_seen++;
    end
    chk("midwr_no_resp", 32'(resp_seen), 32'd0);
    chk("midwr_word2", mem[2], 32'h1111_2222);

    // Back-to-back mixed requests with req_valid held high.
    bq[0] = '{1'b1, 2'b10, 1'b0, 7'd16, 32'h1234_8765};
    bq[1] = '{1'b1, 2'b00, 1'b0, 7'd17, 32'h0000_00C3};
    bq[2] = '{1'b0, 2'b01, 1'b0, 7'd16, 32'h0};
    bq[3] = '{1'b0, 2'b10, 1'b0, 7'd16, 32'h0};
    for (int i = 0; i < 4; i++) begin
      ref_access(bq[i].we, bq[i].sz, bq[i].uns, bq[i].addr, bq[i].wd, re, rr, rl);
      exp_rd_q.push_back(rr);
      exp_err_q.push_back(re);
    end
    fork
      begin
        idx = 0;
        cyc = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        while (idx < 4 && cyc < 40) begin
          bus.req_we = bq[idx].we;
          bus.req_size = bq[idx].sz;
          bus.req_unsigned = bq[idx].uns;
          bus.req_addr = bq[idx].addr;
          bus.req_wdata = bq[idx].wd;
          accepted = bus.req_ready;
          @(negedge clk);
          cyc++;
          if (accepted) begin
            idx++;
            chk("b2b_ready_busy", 32'(bus.req_ready), 32'd0);
          end
        end
        bus.req_valid = 1'b0;
        chk("b2b_all_accepted", 32'(idx), 32'd4);
      end
      begin
        repeat (50) begin
          @(negedge clk);
          if (bus.resp_valid) begin
            got_rd_q.push_back(bus.resp_rdata);
            got_err_q.push_back(bus.resp_err);
          end
        end
      end
    join
    chk("b2b_resp_count", 32'(got_rd_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_rd_q.size()) begin
        chk($sformatf("b2b%0d_rdata", i), got_rd_q[i], exp_rd_q[i]);
        chk($sformatf("b2b%0d_err", i), 32'(got_err_q[i]), 32'(exp_err_q[i]));
      end
    end

    // Randomized requests against the byte-level model.
    for (int i = 0; i < 300; i++) begin
      logic        t_we, t_uns;
      logic [1:0]  t_sz;
      logic [6:0]  t_addr;
      logic [31:0] t_wd;
      t_we = 1'($urandom_range(0, 1));
      t_uns = 1'($urandom_range(0, 1));
      t_sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      t_addr = 7'($urandom);
      if ($urandom_range(0, 3) != 0)
        t_addr = t_addr & ~((7'd1 << t_sz) - 7'd1);
      t_wd = $urandom;
      do_req(t_we, t_sz, t_uns, t_addr, t_wd, e, r, l, nr, nw, ma, h);
      ref_access(t_we, t_sz, t_uns, t_addr, t_wd, re, rr, rl);
      chk($sformatf("rnd%0d_err", i), 32'(e), 32'(re));
      chk($sformatf("rnd%0d_rdata", i), r, rr);
      chk($sformatf("rnd%0d_latency", i), 32'(l), 32'(rl));
      chk($sformatf("rnd%0d_rdata_hold", i), h, rr);
    end
    for (int w = 0; w < 32; w++)
      chk($sformatf("final_word%0d", w), mem[w],
          {refm[4 * w + 3], refm[4 * w + 2], refm[4 * w + 1], refm[4 * w]});
    chk("orphan_resp_err", 32'(orphan_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
